// File: rtl/controller_fifo_serializer.sv
// ============================================================================
// Module   : controller_fifo_serializer
// Purpose  : FIFO that takes a packet of wr_pkt entries per accepted write
//            and hands them out one entry per accepted read. Slice 0 of the
//            write packet is read first.
// Revision : 1.0 - initial release
//
// Parameters
//   abits  : address width, storage depth is 2**abits entries
//   dbits  : entry width in bits
//   wr_pkt : entries stored per accepted write (1 .. 2**abits)
//
// Ports
//   clk     in   system clock, rising edge
//   reset_n in   asynchronous active-low reset
//   wr      in   write request, accepted when full=0
//   rd      in   read request, accepted when empty=0
//   din     in   write packet, dbits*wr_pkt bits
//   dout    out  read data, registered, 1-cycle latency
//   empty   out  no entries stored
//   full    out  fewer than wr_pkt free entries
//   level   out  stored entry count, 0 .. 2**abits
//   ovf     out  sticky write-while-full flag  (CONTROLLER_FIFO_ERR_FLAGS_EN)
//   udf     out  sticky read-while-empty flag  (CONTROLLER_FIFO_ERR_FLAGS_EN)
//
// Build option
//   CONTROLLER_FIFO_ERR_FLAGS_EN : define to add the ovf/udf error flags.
// ============================================================================
`default_nettype none

module controller_fifo_serializer #(
  parameter int abits  = 4,
  parameter int dbits  = 2,
  parameter int wr_pkt = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [dbits*wr_pkt-1:0] din,
  output logic [dbits-1:0]        dout,
  output logic                    empty,
  output logic                    full,
  output logic [abits:0]          level
`ifdef CONTROLLER_FIFO_ERR_FLAGS_EN
  ,
  output logic                    ovf,
  output logic                    udf
`endif
);

  localparam int             depth    = 1 << abits;
  localparam logic [abits:0] depth_lv = (abits+1)'(depth);
  localparam logic [abits:0] pkt_lv   = (abits+1)'(wr_pkt);

  logic [dbits-1:0] mem [depth];
  logic [abits-1:0] wr_ptr;
  logic [abits-1:0] rd_ptr;
  logic [abits:0]   free_cnt;
  logic             wr_ok;
  logic             rd_ok;

  // Flags come straight from the registered level, so a simultaneous
  // read cannot make room for a write in the same cycle.
  assign free_cnt = depth_lv - level;
  assign empty    = (level == '0);
  assign full     = (free_cnt < pkt_lv);
  assign wr_ok    = wr & ~full;
  assign rd_ok    = rd & ~empty;

  // Storage is not reset; the pointers and level define what is valid.
  // The pointer sum wraps naturally, so a packet may straddle slot 0.
  always_ff @(posedge clk) begin : storage
    if (wr_ok && reset_n) begin
      for (int k = 0; k < wr_pkt; k++) begin
        mem[wr_ptr + abits'(k)] <= din[k*dbits +: dbits];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : control
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + abits'(wr_pkt);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      // Net change is +wr_pkt, -1, or +wr_pkt-1 when both are accepted.
      level <= level + (wr_ok ? pkt_lv : '0) - {{abits{1'b0}}, rd_ok};
    end
  end

`ifdef CONTROLLER_FIFO_ERR_FLAGS_EN
  // Sticky until reset: record any attempt that the flags refused.
  always_ff @(posedge clk or negedge reset_n) begin : err_flags
    if (!reset_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr && full) begin
        ovf <= 1'b1;
      end
      if (rd && empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_controller_fifo_serializer.sv
// ============================================================================
// Module   : tb_controller_fifo_serializer
// Purpose  : Self-checking bench for controller_fifo_serializer. A table of
//            directed vectors drives the default instance; hand sequences
//            cover asynchronous reset, a 4-deep single-entry FIFO and a
//            packet that straddles the pointer wrap point.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller_fifo_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // default instance: abits=4, dbits=2, wr_pkt=4
  logic       wr, rd;
  logic [7:0] din;
  logic [1:0] dout;
  logic       empty, full;
  logic [4:0] level;
  logic       ovf, udf;

  // plain FIFO instance: abits=2, dbits=2, wr_pkt=1
  logic       s_wr, s_rd;
  logic [1:0] s_din, s_dout;
  logic       s_empty, s_full;
  logic [2:0] s_level;
  logic       s_ovf, s_udf;

  // wrap instance: abits=3, dbits=2, wr_pkt=3
  logic       w_wr, w_rd;
  logic [5:0] w_din;
  logic [1:0] w_dout;
  logic       w_empty, w_full;
  logic [3:0] w_level;
  logic       w_ovf, w_udf;

`ifndef CONTROLLER_FIFO_ERR_FLAGS_EN
  assign ovf = 1'b0;   assign udf = 1'b0;
  assign s_ovf = 1'b0; assign s_udf = 1'b0;
  assign w_ovf = 1'b0; assign w_udf = 1'b0;
`endif

  controller_fifo_serializer #(.abits(4), .dbits(2), .wr_pkt(4)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .din(din),
    .dout(dout), .empty(empty), .full(full), .level(level)
`ifdef CONTROLLER_FIFO_ERR_FLAGS_EN
    , .ovf(ovf), .udf(udf)
`endif
  );

  controller_fifo_serializer #(.abits(2), .dbits(2), .wr_pkt(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .wr(s_wr), .rd(s_rd), .din(s_din),
    .dout(s_dout), .empty(s_empty), .full(s_full), .level(s_level)
`ifdef CONTROLLER_FIFO_ERR_FLAGS_EN
    , .ovf(s_ovf), .udf(s_udf)
`endif
  );

  controller_fifo_serializer #(.abits(3), .dbits(2), .wr_pkt(3)) dut_w (
    .clk(clk), .reset_n(reset_n), .wr(w_wr), .rd(w_rd), .din(w_din),
    .dout(w_dout), .empty(w_empty), .full(w_full), .level(w_level)
`ifdef CONTROLLER_FIFO_ERR_FLAGS_EN
    , .ovf(w_ovf), .udf(w_udf)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr, rd;
    logic [7:0] din;
    logic [1:0] dout;
    logic [4:0] level;
    logic       empty, full, ovf, udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic r, logic [7:0] d, logic [1:0] q,
                              logic [4:0] l, logic e, logic f, logic o, logic u);
    vec_t v;
    v.wr = w; v.rd = r; v.din = d; v.dout = q; v.level = l;
    v.empty = e; v.full = f; v.ovf = o; v.udf = u;
    return v;
  endfunction

  // drive main instance at the falling edge, sample 1 time unit after rising
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr = w; rd = r; din = d;
    @(posedge clk); #1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic s_step(input logic w, input logic r, input logic [1:0] d);
    @(negedge clk);
    s_wr = w; s_rd = r; s_din = d;
    @(posedge clk); #1;
    @(negedge clk);
    s_wr = 1'b0; s_rd = 1'b0;
  endtask

  task automatic w_step(input logic w, input logic r, input logic [5:0] d);
    @(negedge clk);
    w_wr = w; w_rd = r; w_din = d;
    @(posedge clk); #1;
    @(negedge clk);
    w_wr = 1'b0; w_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] s_exp [4];
    logic [1:0] w_exp [6];

    wr = 0; rd = 0; din = '0;
    s_wr = 0; s_rd = 0; s_din = '0;
    w_wr = 0; w_rd = 0; w_din = '0;
    reset_n = 1'b1;

    //        wr rd din    dout lvl e  f  ovf udf
    vecs.push_back(mk(1, 0, 8'hE4, 0,  4, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0,  3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1,  2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 2,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 3,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 3,  0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 3,  0, 1, 0, 0, 1)); // underflow
    vecs.push_back(mk(1, 0, 8'h1B, 3,  4, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'hE4, 3,  8, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'hAA, 3, 12, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h72, 3, 16, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 8'hFF, 3, 16, 0, 1, 1, 1)); // overflow
    vecs.push_back(mk(0, 1, 8'h00, 3, 15, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 2, 14, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 1, 13, 0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 8'hFF, 0, 12, 0, 0, 1, 1)); // wr dropped
    vecs.push_back(mk(0, 1, 8'h00, 0, 11, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 1, 10, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 2,  9, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 3,  8, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 2,  7, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 2,  6, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 2,  5, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 8'h1B, 2,  8, 0, 0, 1, 1)); // both accepted
    vecs.push_back(mk(0, 1, 8'h00, 2,  7, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0,  6, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 3,  5, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 1,  4, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 3,  3, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 2,  2, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 1,  1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h00, 0,  0, 1, 0, 1, 1));

    // reset state
    #1 reset_n = 1'b0;
    #2;
    chk("rst_level", level, 0);
    chk("rst_dout", dout, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // table-driven main sequence
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr = vecs[i].wr; rd = vecs[i].rd; din = vecs[i].din;
      @(posedge clk); #1;
      chk($sformatf("v%0d_dout", i), dout, vecs[i].dout);
      chk($sformatf("v%0d_level", i), level, vecs[i].level);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].empty);
      chk($sformatf("v%0d_full", i), full, vecs[i].full);
`ifdef CONTROLLER_FIFO_ERR_FLAGS_EN
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      chk($sformatf("v%0d_udf", i), udf, vecs[i].udf);
`endif
    end
    @(negedge clk);
    wr = 0; rd = 0;

    // asynchronous reset mid-cycle at level 8 with nonzero dout
    step(1, 0, 8'hE4);
    step(1, 0, 8'h1B);
    step(1, 0, 8'hAA);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
    chk("pre_rst_level", level, 8);
    chk("pre_rst_dout", dout, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_dout", dout, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_udf", udf, 0);
    // requests during reset are ignored
    wr = 1; rd = 1; din = 8'hFF;
    @(posedge clk); #1;
    chk("in_rst_level", level, 0);
    chk("in_rst_dout", dout, 0);
    @(negedge clk);
    wr = 0; rd = 0;
    reset_n = 1'b1;
    step(1, 0, 8'h1B);
    chk("post_rst_level", level, 4);
    step(0, 1, 8'h00);
    chk("post_rst_dout", dout, 3);
    chk("post_rst_level2", level, 3);

    // plain 4-deep FIFO: full only at level 4
    s_exp[0] = 2'd1; s_exp[1] = 2'd2; s_exp[2] = 2'd3; s_exp[3] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      s_step(1, 0, s_exp[i]);
      chk($sformatf("s_wr%0d_level", i), s_level, i + 1);
      chk($sformatf("s_wr%0d_full", i), s_full, (i == 3) ? 1 : 0);
    end
    s_step(1, 0, 2'd3);
    chk("s_ovf_level", s_level, 4);
`ifdef CONTROLLER_FIFO_ERR_FLAGS_EN
    chk("s_ovf_flag", s_ovf, 1);
`endif
    for (int i = 0; i < 4; i++) begin
      s_step(0, 1, 2'd0);
      chk($sformatf("s_rd%0d_dout", i), s_dout, s_exp[i]);
      chk($sformatf("s_rd%0d_level", i), s_level, 3 - i);
    end
    chk("s_empty", s_empty, 1);
    s_step(1, 0, 2'd2);
    s_step(0, 1, 2'd0);
    chk("s_wrap_dout", s_dout, 2);

    // wr_pkt=3 in 8 slots: third packet occupies slots 6,7,0
    w_step(1, 0, {2'd2, 2'd1, 2'd0});
    chk("w_p1_level", w_level, 3);
    chk("w_p1_full", w_full, 0);
    w_step(1, 0, {2'd1, 2'd3, 2'd2});
    chk("w_p2_level", w_level, 6);
    chk("w_p2_full", w_full, 1);
    w_step(1, 0, 6'h3F);
    chk("w_drop_level", w_level, 6);
    w_exp[0] = 2'd0; w_exp[1] = 2'd1; w_exp[2] = 2'd2;
    for (int i = 0; i < 3; i++) begin
      w_step(0, 1, 6'h00);
      chk($sformatf("w_rdA%0d", i), w_dout, w_exp[i]);
    end
    chk("w_mid_full", w_full, 0);
    w_step(1, 0, {2'd2, 2'd1, 2'd3});
    chk("w_p3_level", w_level, 6);
    w_exp[0] = 2'd2; w_exp[1] = 2'd3; w_exp[2] = 2'd1;
    w_exp[3] = 2'd3; w_exp[4] = 2'd1; w_exp[5] = 2'd2;
    for (int i = 0; i < 6; i++) begin
      w_step(0, 1, 6'h00);
      chk($sformatf("w_rdB%0d", i), w_dout, w_exp[i]);
    end
    chk("w_end_level", w_level, 0);
    chk("w_end_empty", w_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
